ddr_arbiter: RTL and testbench

Four-port round-robin arbiter and sequencer in front of `ddr_controller`'s user command interface. It lets several bus slaves share one DDR controller, such as the wishbone SDRAM slave, a DMA engine, or a video fetch unit. It serialises single-word read/write transactions, drives the controller's command strobe, and waits for the matching completion (`ddr_ack` for writes, `user_data_out_vld` for reads). It returns the result to the granted requester and recovers from a hung controller with a timeout.

---
 rtl/ddr_arbiter.sv | 112 +++++++++++
 tb/tb_ddr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// Four-port round-robin arbiter and sequencer for the DDR controller user command interface.
// It runs one single-word read/write at a time and ends a hung completion with a timeout error.
module ddr_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_stb,
  input  logic [3:0]   req_we,
  input  logic [95:0]  req_addr,
  input  logic [127:0] req_dat_i,
  output logic [3:0]   req_ack,
  output logic [3:0]   req_err,
  output logic [31:0]  req_dat_o,
  output logic         gnt_vld,
  output logic [1:0]   gnt_id,
  output logic [3:0]   user_cmd,
  output logic         user_cmd_vld,
  output logic [23:0]  user_addr,
  output logic [31:0]  user_data_in,
  input  logic [31:0]  user_data_out,
  input  logic         user_data_out_vld,
  input  logic         ddr_ack,
  input  logic         ddr_ready,
  input  logic         ddr_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state;
  logic [1:0]  last;
  logic [16:0] cnt;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        win_vld;
  logic        completion;

  // Search from last+1 upward; iterating downward leaves the nearest requester as the winner.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k) + 2'd1;
      if (req_stb[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Only the completion matching the command type counts.
  assign completion = user_cmd[0] ? ddr_ack : user_data_out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      last         <= 2'd3;
      cnt          <= '0;
      gnt_vld      <= 1'b0;
      gnt_id       <= 2'd0;
      user_cmd     <= 4'd0;
      user_cmd_vld <= 1'b0;
      user_addr    <= 24'd0;
      user_data_in <= 32'd0;
      req_ack      <= 4'd0;
      req_err      <= 4'd0;
      req_dat_o    <= 32'd0;
    end else begin
      user_cmd_vld <= 1'b0;
      req_ack      <= 4'd0;
      req_err      <= 4'd0;
      unique case (state)
        StIdle: begin
          if (ddr_ready && !ddr_busy && win_vld) begin
            state        <= StIssue;
            gnt_vld      <= 1'b1;
            gnt_id       <= win;
            user_cmd     <= {3'd0, req_we[win]};
            user_addr    <= req_addr[24*win +: 24];
            user_data_in <= req_we[win] ? req_dat_i[32*win +: 32] : 32'd0;
            user_cmd_vld <= 1'b1;
            cnt          <= '0;
          end
        end
        StIssue: state <= StWait;
        StWait: begin
          if (completion) begin
            if (!user_cmd[0]) req_dat_o <= user_data_out;
            req_ack <= 4'b0001 << gnt_id;
            state   <= StDone;
          end else if (cnt == 17'(TIMEOUT)) begin
            // Gives ack/err TIMEOUT+2 cycles after the command strobe.
            req_ack   <= 4'b0001 << gnt_id;
            req_err   <= 4'b0001 << gnt_id;
            req_dat_o <= 32'hFFFF_FFFF;
            state     <= StDone;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        StDone: begin
          last    <= gnt_id;
          gnt_vld <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Scoreboard bench for ddr_arbiter: directed requests push expected commands/acks,
// one monitor pops and compares whenever the DUT strobes a command or an ack.
module tb_ddr_arbiter;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_stb = '0;
  logic [3:0]   req_we = '0;
  logic [95:0]  req_addr = '0;
  logic [127:0] req_dat_i = '0;
  logic [3:0]   req_ack, req_err;
  logic [31:0]  req_dat_o;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic [3:0]   user_cmd;
  logic         user_cmd_vld;
  logic [23:0]  user_addr;
  logic [31:0]  user_data_in;
  logic [31:0]  user_data_out = '0;
  logic         user_data_out_vld = 1'b0;
  logic         ddr_ack = 1'b0;
  logic         ddr_ready = 1'b1;
  logic         ddr_busy = 1'b0;

  ddr_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_stb(req_stb), .req_we(req_we), .req_addr(req_addr),
    .req_dat_i(req_dat_i), .req_ack(req_ack), .req_err(req_err), .req_dat_o(req_dat_o),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id), .user_cmd(user_cmd), .user_cmd_vld(user_cmd_vld),
    .user_addr(user_addr), .user_data_in(user_data_in), .user_data_out(user_data_out),
    .user_data_out_vld(user_data_out_vld), .ddr_ack(ddr_ack), .ddr_ready(ddr_ready),
    .ddr_busy(ddr_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  cmd;
    logic [23:0] addr;
    logic [31:0] din;
  } cmd_t;

  typedef struct {
    int          port;
    bit          err;
    bit          rd;
    logic [31:0] dat;
    int          lat;
  } ack_t;

  cmd_t cq[$];
  ack_t aq[$];
  int checks = 0;
  int errors = 0;
  int last_cmd = 0;
  logic [3:0] sticky = '0;

  // Controller model knobs
  bit          resp_en = 1'b1;
  bit          stray = 1'b0;
  int          resp_dly = 2;
  logic [31:0] resp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller model: answers each command after resp_dly cycles; stray answers with the
  // wrong completion type (ddr_ack) regardless of the command.
  initial begin
    bit wr;
    forever begin
      @(negedge clk);
      if (user_cmd_vld && (resp_en || stray)) begin
        wr = user_cmd[0];
        repeat (resp_dly) @(negedge clk);
        if (resp_en && !wr) begin
          user_data_out     = resp_data;
          user_data_out_vld = 1'b1;
        end else begin
          ddr_ack = 1'b1;
        end
        @(negedge clk);
        ddr_ack           = 1'b0;
        user_data_out_vld = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    cmd_t c;
    ack_t a;
    forever begin
      @(negedge clk);
      if (!rst && user_cmd_vld) begin
        last_cmd = cyc;
        if (cq.size() == 0) begin
          check("unexpected_cmd", {31'd0, user_cmd_vld}, 32'd0);
        end else begin
          c = cq.pop_front();
          check("user_cmd", {28'd0, user_cmd}, {28'd0, c.cmd});
          check("user_addr", {8'd0, user_addr}, {8'd0, c.addr});
          check("user_data_in", user_data_in, c.din);
        end
      end
      if (!rst && req_ack != 4'd0) begin
        if (aq.size() == 0) begin
          check("unexpected_ack", {28'd0, req_ack}, 32'd0);
        end else begin
          a = aq.pop_front();
          check("req_ack", {28'd0, req_ack}, 32'(4'b0001 << a.port));
          check("req_err", {28'd0, req_err}, a.err ? 32'(4'b0001 << a.port) : 32'd0);
          if (a.rd) check("req_dat_o", req_dat_o, a.dat);
          if (a.lat >= 0) check("ack_latency", 32'(cyc - last_cmd), 32'(a.lat));
        end
      end
    end
  end

  task automatic set_req(input int p, input bit we, input logic [23:0] a, input logic [31:0] d);
    req_stb[p]           = 1'b1;
    req_we[p]            = we;
    req_addr[24*p +: 24] = a;
    req_dat_i[32*p +: 32] = d;
  endtask

  task automatic exp_txn(input int p, input bit we, input logic [23:0] a, input logic [31:0] d,
                         input logic [31:0] rdat, input bit err, input int lat);
    cmd_t c;
    ack_t k;
    c.cmd  = {3'd0, we};
    c.addr = a;
    c.din  = we ? d : 32'd0;
    cq.push_back(c);
    k.port = p;
    k.err  = err;
    k.rd   = !we;
    k.dat  = rdat;
    k.lat  = lat;
    aq.push_back(k);
  endtask

  // Requester side: drop each strobe on its ack unless sticky; stop after n_acks.
  task automatic run(input int n_acks, input int budget);
    int n = 0;
    int t = 0;
    while (n < n_acks && t < budget) begin
      @(negedge clk);
      t++;
      if (req_ack != 4'd0) begin
        n++;
        if (n == n_acks) req_stb = '0;
        else req_stb = req_stb & ~(req_ack & ~sticky);
      end
    end
    check("ack_count", 32'(n), 32'(n_acks));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!user_cmd_vld && t < budget);
    check("cmd_seen", {31'd0, user_cmd_vld}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, {28'd0, req_ack}, 32'd0);
    check({tag, "_err"}, {28'd0, req_err}, 32'd0);
    check({tag, "_dat_o"}, req_dat_o, 32'd0);
    check({tag, "_gnt_vld"}, {31'd0, gnt_vld}, 32'd0);
    check({tag, "_gnt_id"}, {30'd0, gnt_id}, 32'd0);
    check({tag, "_cmd_vld"}, {31'd0, user_cmd_vld}, 32'd0);
    check({tag, "_addr"}, {8'd0, user_addr}, 32'd0);
    check({tag, "_data_in"}, user_data_in, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Four simultaneous writes from reset: grants 0,1,2,3
    resp_en = 1'b1; resp_dly = 2;
    for (int p = 0; p < 4; p++) begin
      exp_txn(p, 1'b1, 24'h0A0000 | 24'(p), 32'hA5A5_0000 | 32'(p), 32'd0, 1'b0, -1);
      set_req(p, 1'b1, 24'h0A0000 | 24'(p), 32'hA5A5_0000 | 32'(p));
    end
    run(4, 80);

    // Ports 0,1,3 keep requesting: fair order 0,1,3,0,1,3
    sticky = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      exp_txn(0, 1'b1, 24'h300000, 32'hC0DE_0000, 32'd0, 1'b0, -1);
      exp_txn(1, 1'b1, 24'h300001, 32'hC0DE_0001, 32'd0, 1'b0, -1);
      exp_txn(3, 1'b1, 24'h300003, 32'hC0DE_0003, 32'd0, 1'b0, -1);
    end
    set_req(0, 1'b1, 24'h300000, 32'hC0DE_0000);
    set_req(1, 1'b1, 24'h300001, 32'hC0DE_0001);
    set_req(3, 1'b1, 24'h300003, 32'hC0DE_0003);
    run(6, 120);
    sticky = '0;

    // Single read on port 2, data returned 5 cycles after the strobe
    resp_dly = 5; resp_data = 32'hDEAD_BEEF;
    exp_txn(2, 1'b0, 24'h000123, 32'h0, 32'hDEAD_BEEF, 1'b0, 6);
    set_req(2, 1'b0, 24'h000123, 32'h7777_7777);
    run(1, 30);

    // Not ready, then busy: nothing issued until both clear
    resp_dly = 2;
    ddr_ready = 1'b0;
    exp_txn(1, 1'b1, 24'h00ABCD, 32'h1357_9BDF, 32'd0, 1'b0, -1);
    set_req(1, 1'b1, 24'h00ABCD, 32'h1357_9BDF);
    repeat (20) begin
      @(negedge clk);
      check("not_ready_cmd_vld", {31'd0, user_cmd_vld}, 32'd0);
      check("not_ready_gnt_vld", {31'd0, gnt_vld}, 32'd0);
    end
    ddr_ready = 1'b1; ddr_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_gnt_vld", {31'd0, gnt_vld}, 32'd0);
    end
    ddr_busy = 1'b0;
    @(negedge clk);
    check("grant_after_busy", {31'd0, user_cmd_vld}, 32'd1);
    check("grant_after_busy_id", {30'd0, gnt_id}, 32'd1);
    run(1, 20);

    // Timeout on a read of port 1 with a stray ddr_ack during WAIT
    resp_en = 1'b0; stray = 1'b1; resp_dly = 3;
    exp_txn(1, 1'b0, 24'h00BEEF, 32'h0, 32'hFFFF_FFFF, 1'b1, TMO + 2);
    set_req(1, 1'b0, 24'h00BEEF, 32'h0);
    run(1, 40);
    stray = 1'b0; resp_en = 1'b1; resp_dly = 1; resp_data = 32'h1234_5678;
    exp_txn(0, 1'b0, 24'h000042, 32'h0, 32'h1234_5678, 1'b0, 2);
    set_req(0, 1'b0, 24'h000042, 32'h0);
    run(1, 20);

    // Reset in WAIT: outputs clear at once, no ack, port 0 first afterwards
    resp_en = 1'b0;
    begin
      cmd_t c;
      c.cmd = 4'd1; c.addr = 24'h0000F0; c.din = 32'hCAFE_F00D;
      cq.push_back(c);
    end
    set_req(2, 1'b1, 24'h0000F0, 32'hCAFE_F00D);
    wait_cmd(10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    req_stb = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("post_reset_gnt_vld", {31'd0, gnt_vld}, 32'd0);
    resp_en = 1'b1; resp_dly = 2; resp_data = 32'h5A5A_1234;
    exp_txn(0, 1'b0, 24'h000500, 32'h0, 32'h5A5A_1234, 1'b0, 3);
    exp_txn(3, 1'b0, 24'h000503, 32'h0, 32'h5A5A_1234, 1'b0, 3);
    set_req(0, 1'b0, 24'h000500, 32'h0);
    set_req(3, 1'b0, 24'h000503, 32'h0);
    run(2, 40);

    check("cmd_queue_left", 32'(cq.size()), 32'd0);
    check("ack_queue_left", 32'(aq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
